// File: rtl/lii_pkg.sv
// Shared LII widths, arbiter FSM states and the per-beat routing header.
package lii_pkg;

    localparam int unsigned LII_ID_W = 8;
    localparam int unsigned LII_PW   = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [LII_ID_W-1:0] src;
        logic [LII_ID_W-1:0] dst;
    } lii_hdr_t;

endpackage

// File: rtl/lii_rr_pick.sv
// Combinational N-way round-robin picker: first valid requester after 'last', wrapping.
module lii_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] pick_o,
    output logic          any_o
);

    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        pick_o = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IW'((32'(last_i) + k) % N);
            if (!found && valid_i[idx]) begin
                pick_o = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_o = |valid_i;

endmodule

// File: rtl/lii_out_arbiter.sv
// Round-robin arbiter sharing one registered LII phy output among N streams with bounded bursts.
// Define LII_ARB_STATS_EN to add per-requester accepted-beat and output-stall counters.
module lii_out_arbiter
    import lii_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned PW        = LII_PW,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                      aclk,
    input  logic                      arst,
    input  logic [N*PW-1:0]           req_tdata,
    input  logic [N-1:0]              req_tvalid,
    output logic [N-1:0]              req_tready,
    input  logic [N*LII_ID_W-1:0]     req_src,
    input  logic [N*LII_ID_W-1:0]     req_dst,
    output logic [PW-1:0]             lii_out_p0_tdata,
    output logic                      lii_out_p0_tvalid,
    input  logic                      lii_out_p0_tready,
    output logic [LII_ID_W-1:0]       lii_out_p0_src,
    output logic [LII_ID_W-1:0]       lii_out_p0_dst,
    output logic [$clog2(N)-1:0]      grant_id,
    output logic                      busy
`ifdef LII_ARB_STATS_EN
    ,
    output logic [N*32-1:0]           stat_beats,
    output logic [31:0]               stat_stall
`endif
);

    localparam int unsigned IW  = $clog2(N);
    localparam int unsigned BCW = $clog2(MAX_BURST + 1);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [IW-1:0]  last_q, last_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic           tvalid_q, tvalid_d;
    logic [PW-1:0]  tdata_q, tdata_d;
    lii_hdr_t       hdr_q, hdr_d;
    logic [IW-1:0]  pick;
    logic           any_req;
    logic           out_free;
    logic           accept;

    lii_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .valid_i (req_tvalid),
        .last_i  (last_q),
        .pick_o  (pick),
        .any_o   (any_req)
    );

    assign out_free = !tvalid_q || lii_out_p0_tready;

    // Next-state, grant bookkeeping and output-stage load.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        hdr_d       = hdr_q;
        req_tready  = '0;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d     = pick;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                req_tready[grant_q] = out_free;
                accept = req_tvalid[grant_q] && out_free;
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + BCW'(1);
                end
                if ((accept && (burst_cnt_q == BCW'(MAX_BURST - 1))) || !req_tvalid[grant_q]) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled beat is held untouched; otherwise the stage takes the new beat or empties.
        if (out_free) begin
            tvalid_d = accept;
            if (accept) begin
                tdata_d   = req_tdata[32'(grant_q)*PW +: PW];
                hdr_d.src = req_src[32'(grant_q)*LII_ID_W +: LII_ID_W];
                hdr_d.dst = req_dst[32'(grant_q)*LII_ID_W +: LII_ID_W];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= IW'(N - 1);
            burst_cnt_q <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            hdr_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            hdr_q       <= hdr_d;
        end
    end

    assign lii_out_p0_tdata  = tdata_q;
    assign lii_out_p0_tvalid = tvalid_q;
    assign lii_out_p0_src    = hdr_q.src;
    assign lii_out_p0_dst    = hdr_q.dst;
    assign grant_id          = grant_q;
    assign busy              = (state_q == GRANT);

`ifdef LII_ARB_STATS_EN
    logic [31:0] beats_q [N];
    logic [31:0] stall_q;

    always_ff @(posedge aclk) begin
        if (arst) begin
            for (int unsigned i = 0; i < N; i++) begin
                beats_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            if (accept) begin
                beats_q[grant_q] <= beats_q[grant_q] + 32'd1;
            end
            if (tvalid_q && !lii_out_p0_tready) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_stat
        assign stat_beats[g*32 +: 32] = beats_q[g];
    end
    assign stat_stall = stall_q;
`endif

endmodule
